// File: rtl/apb_arbiter_pkg.sv
// apb_arbiter_pkg: shared constants for the APB requester arbiter.
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - address-region decode constants (region field, GPIO/UART codes)
//   - default watchdog limit
//   - region_sel(): region code -> one-hot slave select (0 = decode error)
package apb_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         REGION_HI   = 31;
  localparam int         REGION_LO   = 28;
  localparam logic [3:0] REGION_GPIO = 4'h0;
  localparam logic [3:0] REGION_UART = 4'h1;

  localparam int DEF_TIMEOUT = 16;

  function automatic logic [1:0] region_sel(input logic [3:0] region);
    case (region)
      REGION_GPIO: region_sel = 2'b01;
      REGION_UART: region_sel = 2'b10;
      default:     region_sel = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/apb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   valid : per-requester request vector
//   ptr   : highest-priority requester index this round
//   grant : one-hot winner (all zero when nothing is valid)
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter in front of a single APB master.
//   PCLK/PRESETn        : clock, synchronous active-low reset
//   REQ_*               : packed per-requester command in, grant/done/resp out
//   Transfer, *_in      : command to the APB master (registered, held in BUSY)
//   PENABLE/PREADY/
//   PSLVERR/PRDATA      : bus monitor used for completion and watchdog
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SLAVES_NUM   = 2,
  parameter int REQ_NUM      = 2,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [REQ_NUM-1:0]               REQ_VALID,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]    REQ_WDATA,
  input  logic [REQ_NUM-1:0]               REQ_WRITE,
  input  logic [REQ_NUM*STROBE_WIDTH-1:0]  REQ_STRB,
  input  logic [REQ_NUM*3-1:0]             REQ_PROT,
  output logic [REQ_NUM-1:0]               REQ_GNT,
  output logic [REQ_NUM-1:0]               REQ_DONE,
  output logic [DATA_WIDTH-1:0]            REQ_RDATA,
  output logic                             REQ_ERR,
  output logic                             Transfer,
  output logic [ADDR_WIDTH-1:0]            ADDR_in,
  output logic [DATA_WIDTH-1:0]            DATA_in,
  output logic                             WRITE_in,
  output logic [STROBE_WIDTH-1:0]          STROB_in,
  output logic [2:0]                       PROT_in,
  output logic [SLAVES_NUM-1:0]            SEL_in,
  input  logic                             PENABLE,
  input  logic                             PREADY,
  input  logic                             PSLVERR,
  input  logic [DATA_WIDTH-1:0]            PRDATA
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]            state;
  logic [PW-1:0]         ptr, owner, win_idx;
  logic [REQ_NUM-1:0]    win;
  logic [CW-1:0]         wdog;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_err;
  logic                  handshake, wait_cyc, wd_fire;
  logic [SLAVES_NUM-1:0] win_sel;

  // Unpacked per-requester views of the packed command buses.
  logic [ADDR_WIDTH-1:0]   addr_v [REQ_NUM];
  logic [DATA_WIDTH-1:0]   wdata_v[REQ_NUM];
  logic [STROBE_WIDTH-1:0] strb_v [REQ_NUM];
  logic [2:0]              prot_v [REQ_NUM];

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
    assign addr_v[g]  = REQ_ADDR [g*ADDR_WIDTH   +: ADDR_WIDTH];
    assign wdata_v[g] = REQ_WDATA[g*DATA_WIDTH   +: DATA_WIDTH];
    assign strb_v[g]  = REQ_STRB [g*STROBE_WIDTH +: STROBE_WIDTH];
    assign prot_v[g]  = REQ_PROT [g*3            +: 3];
  end

  rr_pick #(.N(REQ_NUM), .PW(PW)) u_pick (
    .valid(REQ_VALID),
    .ptr  (ptr),
    .grant(win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (win[i]) win_idx = PW'(i);
  end

  assign win_sel   = SLAVES_NUM'(region_sel(addr_v[win_idx][REGION_HI:REGION_LO]));
  assign handshake = PENABLE && PREADY;
  assign wait_cyc  = PENABLE && !PREADY;
  // Fires on the TIMEOUT-th stalled ACCESS cycle.
  assign wd_fire   = (state == ST_BUSY) && wait_cyc && (wdog == CW'(TIMEOUT - 1));
  // Dropping Transfer in the completing cycle sends the master back to IDLE
  // instead of starting a second transfer.
  assign Transfer  = (state == ST_BUSY) && !handshake && !wd_fire;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      wdog      <= '0;
      cap_data  <= '0;
      cap_err   <= 1'b0;
      REQ_GNT   <= '0;
      REQ_DONE  <= '0;
      REQ_RDATA <= '0;
      REQ_ERR   <= 1'b0;
      ADDR_in   <= '0;
      DATA_in   <= '0;
      WRITE_in  <= 1'b0;
      STROB_in  <= '0;
      PROT_in   <= '0;
      SEL_in    <= '0;
    end else begin
      REQ_GNT   <= '0;
      REQ_DONE  <= '0;
      REQ_RDATA <= '0;
      REQ_ERR   <= 1'b0;
      case (state)
        ST_IDLE: if (|REQ_VALID) begin
          owner   <= win_idx;
          REQ_GNT <= win;
          wdog    <= '0;
          if (win_sel == '0) begin
            // Unmapped region: answer with an error, never touch the bus.
            cap_data <= '0;
            cap_err  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            ADDR_in  <= addr_v[win_idx];
            DATA_in  <= wdata_v[win_idx];
            WRITE_in <= REQ_WRITE[win_idx];
            STROB_in <= strb_v[win_idx];
            PROT_in  <= prot_v[win_idx];
            SEL_in   <= win_sel;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (handshake || wd_fire) begin
            cap_data <= (handshake && !WRITE_in) ? PRDATA : '0;
            cap_err  <= wd_fire ? 1'b1 : PSLVERR;
            ADDR_in  <= '0;
            DATA_in  <= '0;
            WRITE_in <= 1'b0;
            STROB_in <= '0;
            PROT_in  <= '0;
            SEL_in   <= '0;
            state    <= ST_DONE;
          end else if (wait_cyc) begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_DONE: begin
          REQ_DONE  <= REQ_NUM'(1) << owner;
          REQ_RDATA <= cap_data;
          REQ_ERR   <= cap_err;
          ptr       <= (owner == PW'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: scoreboard bench for apb_arbiter with a behavioural
// APB master/slave pair (configurable wait states, hang, error, read data).
module tb_apb_arbiter;

  localparam int AW = 32, DW = 32, SW = 4, NS = 2, RN = 2, TO = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [RN-1:0]     REQ_VALID = '0;
  logic [RN*AW-1:0]  REQ_ADDR = '0;
  logic [RN*DW-1:0]  REQ_WDATA = '0;
  logic [RN-1:0]     REQ_WRITE = '0;
  logic [RN*SW-1:0]  REQ_STRB = '0;
  logic [RN*3-1:0]   REQ_PROT = '0;
  logic [RN-1:0]     REQ_GNT, REQ_DONE;
  logic [DW-1:0]     REQ_RDATA;
  logic              REQ_ERR, Transfer, WRITE_in;
  logic [AW-1:0]     ADDR_in;
  logic [DW-1:0]     DATA_in;
  logic [SW-1:0]     STROB_in;
  logic [2:0]        PROT_in;
  logic [NS-1:0]     SEL_in;
  logic              PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]     PRDATA;

  always #5 PCLK = ~PCLK;

  apb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STROBE_WIDTH(SW),
                .SLAVES_NUM(NS), .REQ_NUM(RN), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WRITE(REQ_WRITE), .REQ_STRB(REQ_STRB),
    .REQ_PROT(REQ_PROT), .REQ_GNT(REQ_GNT), .REQ_DONE(REQ_DONE),
    .REQ_RDATA(REQ_RDATA), .REQ_ERR(REQ_ERR), .Transfer(Transfer),
    .ADDR_in(ADDR_in), .DATA_in(DATA_in), .WRITE_in(WRITE_in),
    .STROB_in(STROB_in), .PROT_in(PROT_in), .SEL_in(SEL_in),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  // ---------------- bus model ----------------
  localparam int B_IDLE = 0, B_SETUP = 1, B_ACC = 2;
  int          bst = B_IDLE;
  int          wait_left = 0;
  int          cfg_wait = 0;
  bit          hang = 1'b0;
  bit          slverr_v = 1'b0;
  logic [31:0] rd_val = '0;

  assign PENABLE = (bst == B_ACC);
  assign PREADY  = PENABLE && !hang && (wait_left == 0);
  assign PRDATA  = PREADY ? rd_val : '0;
  assign PSLVERR = PREADY && slverr_v;

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      bst       <= B_IDLE;
      wait_left <= 0;
    end else begin
      case (bst)
        B_IDLE:  if (Transfer) bst <= B_SETUP;
        B_SETUP: begin bst <= B_ACC; wait_left <= cfg_wait; end
        default: begin
          if (PREADY)         bst <= Transfer ? B_SETUP : B_IDLE;
          else if (!Transfer) bst <= B_IDLE;
          else if (wait_left > 0) wait_left <= wait_left - 1;
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          req;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  exp_t mon_e;
  int   gnt_t = 0, done_t = -100;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (|REQ_DONE) begin
        if (exp_q.size() == 0) chk("done_unexp", REQ_DONE, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("done_idx", REQ_DONE, 64'(1) << mon_e.req);
          chk("rdata",    REQ_RDATA, mon_e.rdata);
          chk("err",      REQ_ERR,   mon_e.err);
          chk("latency",  cyc - gnt_t, mon_e.lat);
          done_t = cyc;
        end
      end
      if (|REQ_GNT) begin
        if (exp_q.size() == 0) chk("gnt_unexp", REQ_GNT, 0);
        else begin
          mon_e = exp_q[0];
          chk("gnt_idx", REQ_GNT, 64'(1) << mon_e.req);
          chk("sel",     SEL_in,  mon_e.sel);
          if (mon_e.sel != 2'b00) begin
            chk("addr",  ADDR_in,  mon_e.addr);
            chk("wdata", DATA_in,  mon_e.wdata);
            chk("write", WRITE_in, mon_e.wr);
            chk("xfer",  Transfer, 1);
          end else begin
            chk("xfer_dec", Transfer, 0);
          end
          if (mon_e.gap) chk("gap", cyc - done_t, 1);
          gnt_t = cyc;
        end
      end
    end
  end

  task automatic expect_tx(input int r, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wr, input logic [31:0] rdata,
                           input logic err, input int lat, input bit gap);
    exp_t e;
    e.req = r; e.sel = sel; e.addr = addr; e.wdata = wdata; e.wr = wr;
    e.rdata = rdata; e.err = err; e.lat = lat; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Raise a request, hold it until granted, then drop it.
  task automatic drive(input int r, input logic [31:0] addr, input logic [31:0] data,
                       input logic wr);
    REQ_ADDR[r*AW +: AW]  = addr;
    REQ_WDATA[r*DW +: DW] = data;
    REQ_WRITE[r]          = wr;
    REQ_STRB[r*SW +: SW]  = '1;
    REQ_PROT[r*3 +: 3]    = 3'b010;
    REQ_VALID[r]          = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if (REQ_GNT[r]) break;
    end
    if (!REQ_GNT[r]) chk("gnt_wait", REQ_GNT[r], 1);
    REQ_VALID[r] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge PCLK);
    end
    if (exp_q.size() != 0) begin
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge PCLK);
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_gnt"},   REQ_GNT,   0);
    chk({pfx, "_done"},  REQ_DONE,  0);
    chk({pfx, "_xfer"},  Transfer,  0);
    chk({pfx, "_sel"},   SEL_in,    0);
    chk({pfx, "_addr"},  ADDR_in,   0);
    chk({pfx, "_data"},  DATA_in,   0);
    chk({pfx, "_wr"},    WRITE_in,  0);
    chk({pfx, "_err"},   REQ_ERR,   0);
    chk({pfx, "_rdata"}, REQ_RDATA, 0);
  endtask

  initial begin
    repeat (3) @(negedge PCLK);
    chk_idle_outputs("rst");
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write from requester 0; write returns 0 despite bus data.
    rd_val = 32'hDEAD_BEEF; cfg_wait = 0;
    expect_tx(0, 2'b01, 32'h0000_0010, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0, 4, 1'b0);
    drive(0, 32'h0000_0010, 32'hA5A5_A5A5, 1'b1);
    drain();

    // Read from UART with two wait states.
    rd_val = 32'h0000_00FF; cfg_wait = 2;
    expect_tx(1, 2'b10, 32'h1000_0004, 32'h0, 1'b0, 32'hFF, 1'b0, 6, 1'b0);
    drive(1, 32'h1000_0004, 32'h0, 1'b0);
    drain();

    // Unmapped region: error one cycle after grant, no bus activity.
    expect_tx(1, 2'b00, 32'h2000_0000, 32'h0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    drive(1, 32'h2000_0000, 32'h0, 1'b0);
    drain();

    // Both requesters continuously valid: strict alternation, back-to-back.
    cfg_wait = 0;
    expect_tx(0, 2'b01, 32'h0000_0100, 32'h1111_0000, 1'b1, 32'h0, 1'b0, 4, 1'b0);
    expect_tx(1, 2'b10, 32'h1000_0100, 32'h2222_0000, 1'b1, 32'h0, 1'b0, 4, 1'b1);
    expect_tx(0, 2'b01, 32'h0000_0104, 32'h3333_0000, 1'b1, 32'h0, 1'b0, 4, 1'b1);
    expect_tx(1, 2'b10, 32'h1000_0104, 32'h4444_0000, 1'b1, 32'h0, 1'b0, 4, 1'b1);
    fork
      begin drive(0, 32'h0000_0100, 32'h1111_0000, 1'b1); drive(0, 32'h0000_0104, 32'h3333_0000, 1'b1); end
      begin drive(1, 32'h1000_0100, 32'h2222_0000, 1'b1); drive(1, 32'h1000_0104, 32'h4444_0000, 1'b1); end
    join
    drain();

    // Slave never ready: watchdog ends it after 16 stalled cycles.
    hang = 1'b1; rd_val = 32'h1234_5678;
    expect_tx(0, 2'b01, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 1'b1, 19, 1'b0);
    drive(0, 32'h0000_0020, 32'h0, 1'b0);
    drain();
    hang = 1'b0;

    // Slave error on completion.
    slverr_v = 1'b1; cfg_wait = 1;
    expect_tx(1, 2'b10, 32'h1000_0008, 32'hCAFE_0001, 1'b1, 32'h0, 1'b1, 5, 1'b0);
    drive(1, 32'h1000_0008, 32'hCAFE_0001, 1'b1);
    drain();
    slverr_v = 1'b0; cfg_wait = 0;

    // Serve requester 0 so the pointer favours 1, then reset mid-transfer.
    rd_val = 32'h0000_005A;
    expect_tx(0, 2'b01, 32'h0000_0030, 32'h0, 1'b0, 32'h5A, 1'b0, 4, 1'b0);
    drive(0, 32'h0000_0030, 32'h0, 1'b0);
    drain();
    hang = 1'b1;
    expect_tx(1, 2'b10, 32'h1000_0000, 32'h0, 1'b0, 32'h0, 1'b0, 4, 1'b0);
    drive(1, 32'h1000_0000, 32'h0, 1'b0);
    repeat (5) @(negedge PCLK);
    PRESETn = 1'b0;
    exp_q.delete();
    @(negedge PCLK);
    chk_idle_outputs("midrst");
    PRESETn = 1'b1;
    hang = 1'b0;
    @(negedge PCLK);

    // After reset the pointer is back at 0: requester 0 wins first.
    expect_tx(0, 2'b01, 32'h0000_0040, 32'h0, 1'b0, 32'h5A, 1'b0, 4, 1'b0);
    expect_tx(1, 2'b10, 32'h1000_0040, 32'h0, 1'b0, 32'h5A, 1'b0, 4, 1'b1);
    fork
      drive(0, 32'h0000_0040, 32'h0, 1'b0);
      drive(1, 32'h1000_0040, 32'h0, 1'b0);
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
